// File: rtl/clk_mon_pkg.sv
// Shared types and default sizing for the PHI2 clock monitor.
package clk_mon_pkg;

    // Measurement FSM: ARM waits for a reference rising edge, MEASURE times periods.
    typedef enum logic {
        ARM     = 1'b0,
        MEASURE = 1'b1
    } mon_state_t;

    localparam int unsigned DEF_CNT_W      = 8;
    localparam int unsigned DEF_MIN_PERIOD = 3;
    localparam int unsigned DEF_MAX_PERIOD = 6;
    localparam int unsigned DEF_TIMEOUT    = 64;

endpackage

// File: rtl/phi2_clock_monitor_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; both flops reset to 0.
module sync_2ff (
    input  logic clk_12MHz,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Double-register the asynchronous input into the clk_12MHz domain.
    always_ff @(posedge clk_12MHz) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/phi2_clock_monitor.sv
// PHI2 clock monitor: synchronizes PHI2, emits edge strobes, measures period and
// high time in clk_12MHz cycles, and flags out-of-range or lost clocks.
module phi2_clock_monitor
    import clk_mon_pkg::*;
#(
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned MIN_PERIOD = DEF_MIN_PERIOD,
    parameter int unsigned MAX_PERIOD = DEF_MAX_PERIOD,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
    input  logic             clk_12MHz,
    input  logic             rst,
    input  logic             phi2_in,
    output logic             rise_stb,
    output logic             fall_stb,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             out_of_range,
    output logic             clk_lost
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_PERIOD);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic             phi2_s;
    logic             phi2_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] high_tmp;
    logic             fall_seen;
    mon_state_t       state_q;
    mon_state_t       state_d;
    logic             take_meas;
    logic             timeout_hit;
    logic             capture_high;

    sync_2ff u_sync (
        .clk_12MHz (clk_12MHz),
        .rst       (rst),
        .d         (phi2_in),
        .q         (phi2_s)
    );

    // Delayed copy of the synchronized clock and registered edge strobes.
    always_ff @(posedge clk_12MHz) begin
        if (rst) begin
            phi2_d   <= 1'b0;
            rise_stb <= 1'b0;
            fall_stb <= 1'b0;
        end else begin
            phi2_d   <= phi2_s;
            rise_stb <= phi2_s & ~phi2_d;
            fall_stb <= ~phi2_s & phi2_d;
        end
    end

    // Saturating cycle counter, restarted at 1 on every rising strobe.
    always_ff @(posedge clk_12MHz) begin
        if (rst) begin
            cnt <= '0;
        end else if (rise_stb) begin
            cnt <= CNT_W'(1);
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk_12MHz) begin
        if (rst) begin
            state_q <= ARM;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a rise arms measurement; timeout without a rise disarms it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARM: begin
                if (rise_stb) begin
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (!rise_stb && (cnt == TIMEOUT_C)) begin
                    state_d = ARM;
                end
            end
            default: state_d = ARM;
        endcase
    end

    // FSM outputs: decode which measurement action applies this cycle.
    always_comb begin
        take_meas    = 1'b0;
        timeout_hit  = 1'b0;
        capture_high = 1'b0;
        if (state_q == MEASURE) begin
            take_meas    = rise_stb;
            timeout_hit  = !rise_stb && (cnt == TIMEOUT_C);
            capture_high = fall_stb;
        end
    end

    // Measurement and status registers.
    always_ff @(posedge clk_12MHz) begin
        if (rst) begin
            high_tmp     <= '0;
            fall_seen    <= 1'b0;
            period       <= '0;
            high_time    <= '0;
            meas_valid   <= 1'b0;
            out_of_range <= 1'b0;
            clk_lost     <= 1'b0;
        end else begin
            meas_valid <= take_meas;
            if (capture_high) begin
                high_tmp  <= cnt;
                fall_seen <= 1'b1;
            end
            // Any rise opens a new high phase, including the arming rise.
            if (rise_stb) begin
                fall_seen <= 1'b0;
            end
            if (take_meas) begin
                period       <= cnt;
                high_time    <= fall_seen ? high_tmp : '0;
                out_of_range <= (cnt < MIN_C) || (cnt > MAX_C);
                clk_lost     <= 1'b0;
            end
            if (timeout_hit) begin
                clk_lost <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_phi2_clock_monitor.sv
// Self-checking bench for phi2_clock_monitor against a timestamp-based reference model.
module tb_phi2_clock_monitor;

    localparam int TIMEOUT = 64;

    logic       clk_12MHz = 1'b0;
    logic       rst, rst2;
    logic       phi2_in, phi2_b;
    logic       rise_stb, fall_stb, meas_valid, out_of_range, clk_lost;
    logic [7:0] period, high_time;
    logic       rise_stb2, fall_stb2, meas_valid2, out_of_range2, clk_lost2;
    logic [7:0] period2, high_time2;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: edge indices of strobes and derived expectations.
    int cyc = 0;
    bit smp_q[$];
    bit measuring;
    int last_rise;
    bit fall_seen_m;
    int fall_cnt;
    bit prev_rise, prev_fall;
    int exp_period, exp_high;
    bit exp_valid, exp_oor, exp_lost, exp_rise, exp_fall;

    int got_p, got_h, got_o;

    always #5 clk_12MHz = ~clk_12MHz;

    phi2_clock_monitor dut (
        .clk_12MHz    (clk_12MHz),
        .rst          (rst),
        .phi2_in      (phi2_in),
        .rise_stb     (rise_stb),
        .fall_stb     (fall_stb),
        .period       (period),
        .high_time    (high_time),
        .meas_valid   (meas_valid),
        .out_of_range (out_of_range),
        .clk_lost     (clk_lost)
    );

    phi2_clock_monitor #(.CNT_W(8), .MIN_PERIOD(3), .MAX_PERIOD(6), .TIMEOUT(255)) dut2 (
        .clk_12MHz    (clk_12MHz),
        .rst          (rst2),
        .phi2_in      (phi2_b),
        .rise_stb     (rise_stb2),
        .fall_stb     (fall_stb2),
        .period       (period2),
        .high_time    (high_time2),
        .meas_valid   (meas_valid2),
        .out_of_range (out_of_range2),
        .clk_lost     (clk_lost2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock, update the model from what was sampled, compare every output.
    task automatic step();
        bit smp, rs;
        int cnt_prev;
        smp = phi2_in;
        rs  = rst;
        @(posedge clk_12MHz);
        #1;
        cyc++;
        if (rs) begin
            smp_q = '{0, 0, 0, 0};
            measuring = 0; fall_seen_m = 0; prev_rise = 0; prev_fall = 0;
            exp_period = 0; exp_high = 0; exp_valid = 0; exp_oor = 0; exp_lost = 0;
            exp_rise = 0; exp_fall = 0;
        end else begin
            exp_valid = 0;
            cnt_prev = cyc - 1 - last_rise;
            if (cnt_prev > 255) cnt_prev = 255;
            if (measuring) begin
                if (prev_rise) begin
                    exp_valid  = 1;
                    exp_period = cnt_prev;
                    exp_high   = fall_seen_m ? fall_cnt : 0;
                    exp_oor    = (cnt_prev < 3) || (cnt_prev > 6);
                    exp_lost   = 0;
                    last_rise  = cyc - 1;
                    fall_seen_m = 0;
                end else begin
                    if (prev_fall) begin
                        fall_seen_m = 1;
                        fall_cnt    = cnt_prev;
                    end
                    if (cnt_prev == TIMEOUT) begin
                        exp_lost  = 1;
                        measuring = 0;
                    end
                end
            end else if (prev_rise) begin
                measuring   = 1;
                last_rise   = cyc - 1;
                fall_seen_m = 0;
            end
            smp_q.push_front(smp);
            void'(smp_q.pop_back());
            // Input sampled two edges ago vs three edges ago defines the strobe now.
            exp_rise  = smp_q[2] && !smp_q[3];
            exp_fall  = !smp_q[2] && smp_q[3];
            prev_rise = exp_rise;
            prev_fall = exp_fall;
        end
        check("rise_stb",     rise_stb,     exp_rise);
        check("fall_stb",     fall_stb,     exp_fall);
        check("meas_valid",   meas_valid,   exp_valid);
        check("period",       period,       exp_period);
        check("high_time",    high_time,    exp_high);
        check("out_of_range", out_of_range, exp_oor);
        check("clk_lost",     clk_lost,     exp_lost);
        if (meas_valid) begin
            got_p = period;
            got_h = high_time;
            got_o = out_of_range;
        end
    endtask

    task automatic toggle(input int half, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            step();
            if ((i + 1) % half == 0) phi2_in = ~phi2_in;
        end
    endtask

    initial begin
        int hi, lo, r2, e0;
        rst = 1'b1; rst2 = 1'b1; phi2_in = 1'b0; phi2_b = 1'b0;
        got_p = 0; got_h = 0; got_o = 0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // 1: 2-cycle half period -> period 4, high 2, in range
        toggle(2, 40);
        check("t1_period", got_p, 4);
        check("t1_high",   got_h, 2);
        check("t1_oor",    got_o, 0);

        // 2: 4-cycle half period -> period 8 out of range, then back to 4
        toggle(4, 48);
        check("t2_period", got_p, 8);
        check("t2_high",   got_h, 4);
        check("t2_oor",    got_o, 1);
        toggle(2, 24);
        check("t2b_period", got_p, 4);
        check("t2b_oor",    got_o, 0);

        // 3: clock stops low -> clk_lost, then restart clears it
        phi2_in = 1'b0;
        repeat (100) step();
        check("t3_lost", clk_lost, 1);
        toggle(2, 20);
        check("t3_relost", clk_lost, 0);
        check("t3_period", got_p, 4);

        // 4: rises exactly TIMEOUT apart -> measurement wins over timeout
        phi2_in = 1'b0;
        toggle(32, 192);
        check("t4_period", got_p, 64);
        check("t4_lost",   clk_lost, 0);

        // 5: one-cycle reset during the high phase
        toggle(2, 10);
        phi2_in = 1'b1;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_period", period, 0);
        check("t5_valid",  meas_valid, 0);
        check("t5_lost",   clk_lost, 0);
        toggle(2, 20);
        check("t5_after", got_p, 4);

        // Randomized half periods with occasional long stalls
        for (int k = 0; k < 60; k++) begin
            hi = $urandom_range(1, 9);
            lo = ($urandom_range(0, 7) == 0) ? $urandom_range(50, 80) : $urandom_range(1, 9);
            phi2_in = 1'b1;
            repeat (hi) step();
            phi2_in = 1'b0;
            repeat (lo) step();
        end

        // 6: TIMEOUT=255 instance, clock stuck high for 300 cycles
        rst2 = 1'b0;
        repeat (4) step();
        phi2_b = 1'b1;
        repeat (2) step();
        phi2_b = 1'b0;
        repeat (2) step();
        e0 = cyc;
        phi2_b = 1'b1;
        r2 = e0 + 3;
        while (cyc < r2 + 1) step();
        check("t6_valid",  meas_valid2, 1);
        check("t6_period", period2, 4);
        while (cyc < r2 + 255) step();
        check("t6_lost_early", clk_lost2, 0);
        step();
        check("t6_lost", clk_lost2, 1);
        while (cyc < e0 + 300) step();
        check("t6_cnt_sat", dut2.cnt, 255);
        check("t6_lost_hold", clk_lost2, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
